servo_pwm_gen: RTL and testbench

SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

---
 rtl/servo_pkg.sv | 40 ++++
 rtl/us_tick_gen.sv | 31 +++
 rtl/servo_pwm_gen.sv | 81 ++++++++
 tb/tb_servo_pwm_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// servo_pkg: constants and helpers shared by servo channels.
//   DEF_*        default clock / frame / clamp settings (Hz, microseconds)
//   width_t      16-bit pulse width in microseconds
//   clamp_res_t  result of the width clamp (applied width + clamped flag)
//   clamp_width  maps a requested width onto the legal servo range
package servo_pkg;

    localparam int unsigned DEF_CLK_HZ    = 50_000_000;
    localparam int unsigned DEF_PERIOD_US = 20000;
    localparam int unsigned DEF_MIN_US    = 500;
    localparam int unsigned DEF_MAX_US    = 2500;

    typedef logic [15:0] width_t;

    typedef struct packed {
        width_t width;
        logic   clamped;
    } clamp_res_t;

    // Zero passes through untouched so software can switch the servo off;
    // any other request is pulled into [min_w, max_w].
    function automatic clamp_res_t clamp_width(input width_t req,
                                               input width_t min_w,
                                               input width_t max_w);
        clamp_res_t r;
        r.width   = req;
        r.clamped = 1'b0;
        if (req == '0) begin
            r.width = '0;
        end else if (req < min_w) begin
            r.width   = min_w;
            r.clamped = 1'b1;
        end else if (req > max_w) begin
            r.width   = max_w;
            r.clamped = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// us_tick_gen: divides clk down to a one-clk strobe every DIV clocks.
//   clk     system clock (rising edge)
//   reset   asynchronous, active-high
//   enable  low holds the divider at zero and suppresses the tick
//   tick    high for one clk when the divider sits at DIV-1
module us_tick_gen #(
    parameter int unsigned DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (!enable || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: single-channel hobby-servo PWM generator.
//   clk           system clock (rising edge)
//   reset         asynchronous, active-high
//   enable        high runs the frame, low idles the output
//   width_in      requested pulse width in us (0 = servo off)
//   pwm           registered pulse output
//   period_start  one-clk strobe following each frame boundary
//   clamped       current frame's width was pulled into [MIN_US, MAX_US]
//   active_width  width applied in the current frame
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned PERIOD_US = DEF_PERIOD_US,
    parameter int unsigned MIN_US    = DEF_MIN_US,
    parameter int unsigned MAX_US    = DEF_MAX_US
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] width_in,
    output logic        pwm,
    output logic        period_start,
    output logic        clamped,
    output logic [15:0] active_width
);

    localparam int unsigned DIV = CLK_HZ / 1_000_000;
    localparam int unsigned UW  = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam logic [UW-1:0] US_LAST = UW'(PERIOD_US - 1);

    logic          tick;
    logic [UW-1:0] us_cnt;
    logic [UW-1:0] us_next;
    logic          wrap;
    clamp_res_t    cres;
    width_t        aw_next;

    us_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    // us_cnt idles at PERIOD_US-1 so the first tick after reset or enable
    // wraps it and opens a fresh frame.
    assign wrap    = tick && (us_cnt == US_LAST);
    assign us_next = wrap ? '0 : us_cnt + UW'(1);
    assign cres    = clamp_width(width_in, width_t'(MIN_US), width_t'(MAX_US));
    // width_in only matters on the boundary tick, so a mid-frame write
    // never reshapes the pulse in flight.
    assign aw_next = wrap ? cres.width : active_width;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            us_cnt       <= US_LAST;
            pwm          <= 1'b0;
            period_start <= 1'b0;
            clamped      <= 1'b0;
            active_width <= '0;
        end else if (!enable) begin
            us_cnt       <= US_LAST;
            pwm          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (tick) begin
                us_cnt <= us_next;
                // Look ahead at the post-tick count/width so pwm is a clean
                // register that rises one clk after the boundary tick.
                pwm    <= (width_t'(us_next) < aw_next);
            end
            if (wrap) begin
                active_width <= cres.width;
                clamped      <= cres.clamped;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
module tb_servo_pwm_gen;

    localparam int DIV   = 4;
    localparam int PER   = 100;
    localparam int MINW  = 10;
    localparam int MAXW  = 50;
    localparam int FRAME = PER * DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] width_in;
    logic        pwm, period_start, clamped;
    logic [15:0] active_width;

    servo_pwm_gen #(
        .CLK_HZ    (4_000_000),
        .PERIOD_US (PER),
        .MIN_US    (MINW),
        .MAX_US    (MAXW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .width_in     (width_in),
        .pwm          (pwm),
        .period_start (period_start),
        .clamped      (clamped),
        .active_width (active_width)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ps;
        int pw;
        int aw;
        int cl;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic cmp(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Legal servo range as a plain rule: 0 stays off, others pulled into range.
    function automatic int ref_width(input int w);
        if (w == 0)        return 0;
        else if (w < MINW) return MINW;
        else if (w > MAXW) return MAXW;
        else               return w;
    endfunction

    // Reference: time-based view of the frame. 'run' counts enabled clock
    // edges since reset/enable; frames open at edges DIV, DIV+FRAME, ...
    // and pwm is high for the first width*DIV edges of each frame.
    initial begin : model
        int   run, fstart, m_aw, m_cl;
        exp_t e;
        run = 0; fstart = 0; m_aw = 0; m_cl = 0;
        forever begin
            @(posedge clk);
            e.ps = 0;
            e.pw = 0;
            if (reset) begin
                run = 0; m_aw = 0; m_cl = 0;
            end else if (!enable) begin
                run = 0;
            end else begin
                run++;
                if (run >= DIV && (run - DIV) % FRAME == 0) begin
                    fstart = run;
                    m_aw   = ref_width(int'(width_in));
                    m_cl   = (m_aw != int'(width_in)) ? 1 : 0;
                    e.ps   = 1;
                end
                if (run >= DIV)
                    e.pw = ((run - fstart) < m_aw * DIV) ? 1 : 0;
            end
            e.aw = m_aw;
            e.cl = m_cl;
            sb.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("pwm",          int'(pwm),          e.pw);
                cmp("period_start", int'(period_start), e.ps);
                cmp("active_width", int'(active_width), e.aw);
                cmp("clamped",      int'(clamped),      e.cl);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        int pick, w;
        reset    = 1'b1;
        enable   = 1'b0;
        width_in = 16'd0;
        #1;
        cmp("reset_pwm", int'(pwm),          0);
        cmp("reset_ps",  int'(period_start), 0);
        cmp("reset_aw",  int'(active_width), 0);
        cmp("reset_cl",  int'(clamped),      0);
        cycles(3);

        // nominal frames, then clamp at both ends
        reset = 1'b0; enable = 1'b1; width_in = 16'd30;
        cycles(DIV + 2 * FRAME);
        width_in = 16'd3;      cycles(FRAME);
        width_in = 16'hFFFF;   cycles(FRAME);
        width_in = 16'd20;     cycles(FRAME);
        // width change 50 clks into a frame must wait for the next frame
        cycles(50); width_in = 16'd40; cycles(FRAME - 50);
        cycles(FRAME);
        width_in = 16'd0;      cycles(2 * FRAME);

        // enable dropped mid-pulse for 37 clks
        width_in = 16'd30;     cycles(FRAME);
        cycles(60); enable = 1'b0; cycles(37); enable = 1'b1;
        cycles(DIV + 50);

        // async reset mid-pulse, between clock edges
        #2 reset = 1'b1;
        #1;
        cmp("async_rst_pwm", int'(pwm),          0);
        cmp("async_rst_aw",  int'(active_width), 0);
        cycles(2);
        reset = 1'b0; width_in = 16'd45;
        cycles(DIV + 2 * FRAME);

        // randomized widths, change points and enable drops
        for (int i = 0; i < 10; i++) begin
            pick = int'($urandom_range(0, 4));
            case (pick)
                0:       w = 0;
                1:       w = int'($urandom_range(1, MINW - 1));
                2:       w = int'($urandom_range(MAXW + 1, 16'hFFFF));
                3:       w = int'($urandom_range(MINW, MAXW));
                default: w = int'($urandom_range(0, 16'hFFFF));
            endcase
            width_in = 16'(w);
            cycles(int'($urandom_range(50, 700)));
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                cycles(int'($urandom_range(1, 50)));
                enable = 1'b1;
            end
        end
        cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
